// File: rtl/noc_pkg.sv
// Shared NoC definitions: port codes, flit type codes, header field positions
// and the XY dimension-order route function.
package noc_pkg;

   typedef enum logic [2:0] {
      PORT_N       = 3'd0,
      PORT_S       = 3'd1,
      PORT_E       = 3'd2,
      PORT_W       = 3'd3,
      PORT_L       = 3'd4,
      PORT_INVALID = 3'd7
   } port_e;

   typedef enum logic [1:0] {
      FT_BODY      = 2'b00,
      FT_HEAD      = 2'b01,
      FT_TAIL      = 2'b10,
      FT_HEAD_TAIL = 2'b11
   } flit_type_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } ib_state_e;

   // Field offsets are counted down from the flit MSB.
   localparam int FT_OFS  = 0;
   localparam int FT_W    = 2;
   localparam int DX_OFS  = 2;
   localparam int DY_OFS  = 6;
   localparam int COORD_W = 4;

   function automatic port_e xy_route(input logic [COORD_W-1:0] dx,
                                      input logic [COORD_W-1:0] dy,
                                      input logic [COORD_W-1:0] lx,
                                      input logic [COORD_W-1:0] ly);
      port_e p;
      if (dx > lx)      p = PORT_E;
      else if (dx < lx) p = PORT_W;
      else if (dy > ly) p = PORT_N;
      else if (dy < ly) p = PORT_S;
      else              p = PORT_L;
      return p;
   endfunction

endpackage

// File: rtl/input_buffer_flit_fifo.sv
// Synchronous flit FIFO, DATA_W x DEPTH; head entry visible combinationally.
// Pushes while full and pops while empty are ignored.
module flit_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              empty_o,
   output logic              full_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/input_buffer.sv
// Router input port: buffers flits, latches the XY route of each head flit and
// requests the matching output until the tail is granted; stray body/tail flits are dropped.
module input_buffer
   import noc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int LOCAL_X = 0,
   parameter int LOCAL_Y = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_flit,
   output logic [4:0]        out_request,
   output logic [2:0]        out_port,
   output logic [DATA_W-1:0] out_flit,
   input  logic              out_grant,
   output logic              drop_err
);
   ib_state_e            state_q, state_d;
   port_e                port_q, port_d;
   logic                 drop_err_q, drop_err_d;
   logic                 fifo_empty, fifo_full;
   logic                 push, pop, drop;
   flit_type_e           head_type;
   logic [COORD_W-1:0]   dest_x, dest_y;
   logic                 head_is_head, head_is_tail;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign out_port = port_q;
   assign drop_err = drop_err_q;

   assign head_type    = flit_type_e'(out_flit[DATA_W-1-FT_OFS -: FT_W]);
   assign dest_x       = out_flit[DATA_W-1-DX_OFS -: COORD_W];
   assign dest_y       = out_flit[DATA_W-1-DY_OFS -: COORD_W];
   assign head_is_head = (head_type == FT_HEAD) || (head_type == FT_HEAD_TAIL);
   assign head_is_tail = (head_type == FT_TAIL) || (head_type == FT_HEAD_TAIL);

   flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_flit),
      .rdata_o (out_flit),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         port_q     <= PORT_INVALID;
         drop_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         drop_err_q <= drop_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      drop_err_d = drop_err_q | drop;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && head_is_head) begin
               state_d = ST_ACTIVE;
               port_d  = xy_route(dest_x, dest_y, 4'(LOCAL_X), 4'(LOCAL_Y));
            end
         end
         ST_ACTIVE: begin
            if (pop && head_is_tail) begin
               state_d = ST_IDLE;
               port_d  = PORT_INVALID;
            end
         end
         default: begin
            state_d = ST_IDLE;
            port_d  = PORT_INVALID;
         end
      endcase
   end

   // A grant only counts while a request is actually raised.
   always_comb begin
      out_request = '0;
      pop         = 1'b0;
      drop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !head_is_head) begin
               pop  = 1'b1;
               drop = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (!fifo_empty) begin
               out_request = 5'b00001 << port_q;
               pop         = out_grant;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer (LOCAL_X=1, LOCAL_Y=1) with a queue-based
// packet model checked every cycle plus hand-computed spot checks.
module tb_input_buffer;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int LX     = 1;
   localparam int LY     = 1;

   logic              clk, reset;
   logic              in_valid, in_ready;
   logic [DATA_W-1:0] in_flit, out_flit;
   logic [4:0]        out_request;
   logic [2:0]        out_port;
   logic              out_grant, drop_err;

   int tests = 0;
   int fails = 0;

   input_buffer #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .LOCAL_X (LX),
      .LOCAL_Y (LY)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_flit     (in_flit),
      .out_request (out_request),
      .out_port    (out_port),
      .out_flit    (out_flit),
      .out_grant   (out_grant),
      .drop_err    (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                      input logic [3:0] dy, input logic [21:0] pl);
      return {t, dx, dy, pl};
   endfunction

   function automatic int route_of(input logic [31:0] f);
      int dx = int'(f[29:26]);
      int dy = int'(f[25:22]);
      if (dx > LX) return 2;
      if (dx < LX) return 3;
      if (dy > LY) return 0;
      if (dy < LY) return 1;
      return 4;
   endfunction

   // Packet-level model: queue of buffered flits, held route, sticky drop flag.
   logic [31:0] mq[$];
   bit          m_held;
   int          m_route;
   bit          m_drop;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_held  = 0;
         m_route = 7;
         m_drop  = 0;
      end else begin
         bit          can_push;
         logic [1:0]  t;
         can_push = (mq.size() != DEPTH);
         if (mq.size() > 0) begin
            t = mq[0][31:30];
            if (!m_held) begin
               if (t == 2'b01 || t == 2'b11) begin
                  m_held  = 1;
                  m_route = route_of(mq[0]);
               end else begin
                  void'(mq.pop_front());
                  m_drop = 1;
               end
            end else if (out_grant) begin
               void'(mq.pop_front());
               if (t == 2'b10 || t == 2'b11) begin
                  m_held  = 0;
                  m_route = 7;
               end
            end
         end
         if (in_valid && can_push) mq.push_back(in_flit);
      end
   end

   always @(negedge clk) begin
      logic [4:0] exp_req;
      exp_req = (m_held && mq.size() > 0) ? (5'b00001 << m_route) : 5'b00000;
      check("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      check("m_out_request", 32'(out_request), 32'(exp_req));
      check("m_out_port", 32'(out_port), 32'(m_route));
      check("m_drop_err", 32'(drop_err), 32'(m_drop));
      if (mq.size() > 0) check("m_out_flit", out_flit, mq[0]);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clk = 0; reset = 1; in_valid = 0; in_flit = '0; out_grant = 0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_request", 32'(out_request), 32'd0);
      check("rst_out_port", 32'(out_port), 32'd7);
      check("rst_drop_err", 32'(drop_err), 32'd0);
      @(negedge clk);
      reset = 0;

      // Single head+tail flit to (3,1): east, request one edge after acceptance.
      in_valid = 1; in_flit = mk(2'b11, 4'd3, 4'd1, 22'h0A1);
      tick();
      in_valid = 0;
      check("t1_req_edge_k", 32'(out_request), 32'd0);
      check("t1_port_edge_k", 32'(out_port), 32'd7);
      tick();
      check("t1_port", 32'(out_port), 32'd2);
      check("t1_req", 32'(out_request), 32'b00100);
      out_grant = 1;
      tick();
      out_grant = 0;
      check("t1_req_after", 32'(out_request), 32'd0);
      check("t1_port_after", 32'(out_port), 32'd7);

      // Head/body/tail to (1,0): south, body arrives late.
      in_valid = 1; in_flit = mk(2'b01, 4'd1, 4'd0, 22'h0B1);
      tick();
      in_valid = 0;
      tick();
      check("t2_port_head", 32'(out_port), 32'd1);
      check("t2_req_head", 32'(out_request), 32'b00010);
      out_grant = 1;
      tick();
      check("t2_req_gap", 32'(out_request), 32'd0);
      check("t2_port_gap", 32'(out_port), 32'd1);
      tick();
      check("t2_port_ignored_grant", 32'(out_port), 32'd1);
      out_grant = 0;
      in_valid = 1; in_flit = mk(2'b00, 4'd0, 4'd0, 22'h0B2);
      tick();
      in_valid = 0;
      check("t2_req_body", 32'(out_request), 32'b00010);
      out_grant = 1;
      tick();
      out_grant = 0;
      in_valid = 1; in_flit = mk(2'b10, 4'd0, 4'd0, 22'h0B3);
      tick();
      in_valid = 0;
      check("t2_port_tail", 32'(out_port), 32'd1);
      out_grant = 1;
      tick();
      out_grant = 0;
      check("t2_port_idle", 32'(out_port), 32'd7);
      check("t2_req_idle", 32'(out_request), 32'd0);

      // Stray body flit is dropped; then head to (1,1) goes local.
      in_valid = 1; in_flit = mk(2'b00, 4'd3, 4'd3, 22'h0C1);
      tick();
      in_valid = 0;
      check("t4_drop_before", 32'(drop_err), 32'd0);
      tick();
      check("t4_drop_set", 32'(drop_err), 32'd1);
      check("t4_req_zero", 32'(out_request), 32'd0);
      in_valid = 1; in_flit = mk(2'b11, 4'd1, 4'd1, 22'h0C2);
      tick();
      in_valid = 0;
      tick();
      check("t4_req_local", 32'(out_request), 32'b10000);
      out_grant = 1;
      tick();
      out_grant = 0;

      // Fill with no grant: head to (2,1) plus three bodies.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1;
         in_flit  = mk((i == 0) ? 2'b01 : 2'b00, 4'd2, 4'd1, 22'(32'h0D0 + i));
         tick();
      end
      check("t3_full", 32'(in_ready), 32'd0);
      in_flit = mk(2'b10, 4'd0, 4'd0, 22'h0DF);
      tick();
      in_valid = 0;
      check("t3_still_full", 32'(in_ready), 32'd0);
      check("t3_head_flit", out_flit, mk(2'b01, 4'd2, 4'd1, 22'h0D0));
      out_grant = 1;
      tick();
      out_grant = 0;
      check("t3_ready_again", 32'(in_ready), 32'd1);
      in_valid = 1; in_flit = mk(2'b00, 4'd0, 4'd0, 22'h0D4);
      tick();
      in_valid = 0;
      check("t3_refull", 32'(in_ready), 32'd0);

      // Reset mid-packet, between edges.
      #2;
      reset = 1;
      #1;
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_req", 32'(out_request), 32'd0);
      check("t5_port", 32'(out_port), 32'd7);
      check("t5_drop", 32'(drop_err), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      #1;
      check("t5_count", 32'(dut.u_fifo.count_q), 32'd0);
      check("t5_ready_rel", 32'(in_ready), 32'd1);
      in_valid = 1; in_flit = mk(2'b11, 4'd0, 4'd1, 22'h0E1);
      tick();
      in_valid = 0;
      tick();
      check("t5_port_west", 32'(out_port), 32'd3);
      check("t5_req_west", 32'(out_request), 32'b01000);
      out_grant = 1;
      tick();
      out_grant = 0;
      check("t5_req_done", 32'(out_request), 32'd0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/input_buffer.md
INPUT_BUFFER -- requirements
Module: input_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, flit width in bits (minimum 12).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, at least 2).
REQ-003 SHALL have parameter LOCAL_X, default 0, this router's 4-bit X coordinate.
REQ-004 SHALL have parameter LOCAL_Y, default 0, this router's 4-bit Y coordinate.
REQ-005 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream flit valid.
REQ-008 SHALL have port in_ready, output, 1, buffer can accept a flit.
REQ-009 SHALL have port in_flit, input, DATA_W, upstream flit.
REQ-010 SHALL have port out_request, output, 5, one-hot request to the output arbiters; bit index equals the port code.
REQ-011 SHALL have port out_port, output, 3, latched route code: N=0, S=1, E=2, W=3, L=4, INVALID=7.
REQ-012 SHALL have port out_flit, output, DATA_W, flit at the FIFO head.
REQ-013 SHALL have port out_grant, input, 1, head flit is consumed this cycle.
REQ-014 SHALL have port drop_err, output, 1, sticky flag: a flit was discarded.

Function
REQ-015 SHALL use this flit layout: type in [DATA_W-1:DATA_W-2] (01 head, 00 body, 10 tail, 11 head+tail); dest_x in [DATA_W-3:DATA_W-6]; dest_y in [DATA_W-7:DATA_W-10].
REQ-016 SHALL push in_flit on a rising edge when in_valid && in_ready; in_valid while in_ready is low has no effect.
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from the occupancy register.
REQ-018 SHALL keep count as a register of clog2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
REQ-019 SHALL, on push and pop in the same edge, leave count unchanged and advance both pointers.
REQ-020 SHALL have an FSM with two states: IDLE (no route held) and ACTIVE (route held).
REQ-021 SHALL, in IDLE with the FIFO non-empty and head type 01 or 11, compute the XY route, latch it into out_port, and enter ACTIVE at the next edge.
REQ-022 SHALL compute the XY route as: dest_x>LOCAL_X gives E; dest_x<LOCAL_X gives W; otherwise dest_y>LOCAL_Y gives N, dest_y<LOCAL_Y gives S, else L.
REQ-023 SHALL, in IDLE with head type 00 or 10, pop that flit at the next edge and set drop_err; the FSM stays in IDLE.
REQ-024 SHALL, in ACTIVE, assert out_request[out_port] only while the FIFO is non-empty; all other out_request bits are 0.
REQ-025 SHALL ignore out_grant whenever out_request is all zero.
REQ-026 SHALL pop on out_grant while requesting; if the popped flit is type 10 or 11, return to IDLE and set out_port to 7 at the same edge.
REQ-027 SHALL assert out_request from the edge after the edge that accepts the head flit into an empty buffer (1-edge latency).
REQ-028 SHALL drive out_port = 7 in IDLE and out_request = 0 in IDLE.
REQ-029 SHALL drive out_flit from the head entry at all times; its value is don't-care when the FIFO is empty.

Reset
REQ-030 SHALL, on reset, immediately force: pointers and count 0, FSM IDLE, out_port 7, out_request 0, drop_err 0, in_ready 1.
REQ-031 SHALL discard all buffered flits on reset mid-packet; the first flit after reset must be a head flit.

Structure
REQ-032 SHALL take port codes, flit type codes, field positions and the XY route function from the shared package noc_pkg.
REQ-033 SHALL instantiate one sub-module, flit_fifo (synchronous FIFO, DATA_W x DEPTH); the FSM and route logic stay in input_buffer.

Verification (LOCAL_X=1, LOCAL_Y=1)
REQ-034 SHALL cover: single head+tail flit, dest (3,1), accepted at edge k -> out_port=2, out_request=5'b00100 after edge k+1; one grant -> IDLE, out_request=0, out_port=7.
REQ-035 SHALL cover: head/body/tail packet, dest (1,0) -> out_port=1 held across three grants; out_request drops to 0 if the body is late; IDLE after the tail.
REQ-036 SHALL cover: 4 flits pushed with no grant -> in_ready=0 after the 4th; a 5th in_valid is not accepted; one grant -> in_ready=1 after that edge.
REQ-037 SHALL cover: body flit arriving first -> popped, drop_err=1, out_request stays 0; a following head, dest (1,1) -> out_request=5'b10000.
REQ-038 SHALL cover: reset asserted mid-packet between clock edges -> outputs take reset values without a clock edge; after release in_ready=1 and count=0.
